// File: rtl/hdc_search_pkg.sv
// Shared types and defaults for the HDC associative-search stage.
// Latency: none (declarations only).
// Backpressure: not applicable.
package hdc_search_pkg;

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    SEARCH = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam int N_CLASSES_DEF = 8;
  localparam int N_FRAMES_DEF  = 3;

  // Width needed to hold a Hamming distance over the whole hypervector (0..frames*w).
  function automatic int dist_w(input int frames, input int w);
    return $clog2(frames * w + 1);
  endfunction

endpackage

// File: rtl/hvec_popcount.sv
// Combinational population count of a W-bit vector.
// Latency: 0 cycles (pure combinational).
// Backpressure: not applicable.
module hvec_popcount #(
  parameter int W    = 64,
  parameter int PC_W = $clog2(W + 1)
) (
  input  logic [W-1:0]    vec,
  output logic [PC_W-1:0] count
);

  // Sum every bit; synthesis builds the adder tree.
  always_comb begin
    count = '0;
    for (int i = 0; i < W; i++) begin
      count = count + PC_W'(vec[i]);
    end
  end

endmodule

// File: rtl/hamming_class_search.sv
// Loads a query hypervector, walks every class/frame of the generator, returns nearest class.
// Latency: N_FRAMES load beats, then N_CLASSES*N_FRAMES search cycles to out_valid.
// Backpressure: in_ready low outside LOAD; result held in DONE until out_ready.
module hamming_class_search
  import hdc_search_pkg::*;
#(
  parameter int DI_PARALLEL_W_BITS = 64,
  parameter int N_CLASSES          = N_CLASSES_DEF,
  parameter int N_FRAMES           = N_FRAMES_DEF,
  parameter int CLASS_ID_W         = $clog2(N_CLASSES),
  parameter int FRAME_IDX_W        = $clog2(N_FRAMES),
  parameter int DIST_W             = dist_w(N_FRAMES, DI_PARALLEL_W_BITS)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [DI_PARALLEL_W_BITS-1:0] in_frame,
  output logic [CLASS_ID_W-1:0]         frame_id,
  output logic [FRAME_IDX_W-1:0]        frame_index,
  input  logic [DI_PARALLEL_W_BITS-1:0] class_vec_in,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [CLASS_ID_W-1:0]         out_class,
  output logic [DIST_W-1:0]             out_dist
);

  localparam int PC_W = $clog2(DI_PARALLEL_W_BITS + 1);
  localparam logic [FRAME_IDX_W-1:0] LAST_FRAME = FRAME_IDX_W'(N_FRAMES - 1);
  localparam logic [CLASS_ID_W-1:0]  LAST_CLASS = CLASS_ID_W'(N_CLASSES - 1);

  state_t state, state_next;

  logic [N_FRAMES-1:0][DI_PARALLEL_W_BITS-1:0] query;
  logic [FRAME_IDX_W-1:0] load_cnt;
  logic [CLASS_ID_W-1:0]  cls_cnt;
  logic [FRAME_IDX_W-1:0] frm_cnt;
  logic [DIST_W-1:0]      acc;
  logic [DIST_W-1:0]      best_dist;
  logic [CLASS_ID_W-1:0]  best_class;

  logic [PC_W-1:0]   pc;
  logic [DIST_W-1:0] sum;
  logic              load_last;
  logic              frame_last;
  logic              search_last;

  hvec_popcount #(.W(DI_PARALLEL_W_BITS), .PC_W(PC_W)) u_popcount (
    .vec   (query[frm_cnt] ^ class_vec_in),
    .count (pc)
  );

  // Distance of the current class so far, including this frame; single-cycle path by design.
  always_comb begin
    sum         = acc + DIST_W'(pc);
    load_last   = in_valid && (load_cnt == LAST_FRAME);
    frame_last  = (frm_cnt == LAST_FRAME);
    search_last = frame_last && (cls_cnt == LAST_CLASS);
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= LOAD;
    else        state <= state_next;
  end

  // Next-state decode and handshake/generator outputs.
  always_comb begin
    state_next  = state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    out_class   = '0;
    out_dist    = '0;
    frame_id    = '0;
    frame_index = '0;
    case (state)
      LOAD: begin
        in_ready = 1'b1;
        if (load_last) state_next = SEARCH;
      end
      SEARCH: begin
        frame_id    = cls_cnt;
        frame_index = frm_cnt;
        if (search_last) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        out_class = best_class;
        out_dist  = best_dist;
        if (out_ready) state_next = LOAD;
      end
      default: state_next = LOAD;
    endcase
  end

  // Query capture, frame/class walk and running minimum; ties keep the earlier (lower) class.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      query      <= '0;
      load_cnt   <= '0;
      cls_cnt    <= '0;
      frm_cnt    <= '0;
      acc        <= '0;
      best_dist  <= '0;
      best_class <= '0;
    end else begin
      case (state)
        LOAD: begin
          if (in_valid) begin
            query[load_cnt] <= in_frame;
            if (load_last) begin
              load_cnt   <= '0;
              cls_cnt    <= '0;
              frm_cnt    <= '0;
              acc        <= '0;
              best_dist  <= '1;
              best_class <= '0;
            end else begin
              load_cnt <= load_cnt + FRAME_IDX_W'(1);
            end
          end
        end
        SEARCH: begin
          if (!frame_last) begin
            acc     <= sum;
            frm_cnt <= frm_cnt + FRAME_IDX_W'(1);
          end else begin
            if (sum < best_dist) begin
              best_dist  <= sum;
              best_class <= cls_cnt;
            end
            acc     <= '0;
            frm_cnt <= '0;
            cls_cnt <= cls_cnt + CLASS_ID_W'(1);
          end
        end
        DONE: begin
          if (out_ready) load_cnt <= '0;
        end
        default: load_cnt <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_hamming_class_search.sv
// Directed bench for hamming_class_search with a behavioural class-vector generator.
// Generator modes: 0 hashed "real" classes, 1 all-ones, 2 classes 2/6 equal query else inverted,
// 3 class c differs from query in (8-c) bits of frame 0.
module tb_hamming_class_search;

  localparam int W  = 64;
  localparam int NC = 8;
  localparam int NF = 3;

  typedef logic [NF-1:0][W-1:0] hv_t;

  typedef struct {
    string      name;
    int         mode;
    hv_t        q;
    logic [2:0] exp_class;
    logic [7:0] exp_dist;
  } vec_t;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_frame;
  logic [2:0]   frame_id;
  logic [1:0]   frame_index;
  logic [W-1:0] class_vec_in;
  logic         out_valid;
  logic         out_ready;
  logic [2:0]   out_class;
  logic [7:0]   out_dist;

  int  n_chk;
  int  n_err;
  int  mode;
  hv_t cur_q;

  hamming_class_search dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_frame     (in_frame),
    .frame_id     (frame_id),
    .frame_index  (frame_index),
    .class_vec_in (class_vec_in),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_class    (out_class),
    .out_dist     (out_dist)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] mix(input int c, input int f);
    logic [W-1:0] x;
    x = 64'(c * NF + f + 1) * 64'h9E3779B97F4A7C15;
    x = x ^ (x >> 31);
    x = x * 64'hBF58476D1CE4E5B9;
    x = x ^ (x >> 29);
    return x;
  endfunction

  // Combinational generator model driven by the DUT's frame_id/frame_index.
  always_comb begin
    logic [W-1:0] m;
    m = (64'd1 << (8 - int'(frame_id))) - 64'd1;
    class_vec_in = '0;
    case (mode)
      0: class_vec_in = mix(int'(frame_id), int'(frame_index));
      1: class_vec_in = '1;
      2: class_vec_in = (frame_id == 3'd2 || frame_id == 3'd6) ? cur_q[frame_index] : ~cur_q[frame_index];
      3: class_vec_in = (frame_index == 2'd0) ? (cur_q[0] ^ m) : cur_q[frame_index];
      default: class_vec_in = '0;
    endcase
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  function automatic hv_t class_hv(input int c);
    hv_t h;
    for (int f = 0; f < NF; f++) h[f] = mix(c, f);
    return h;
  endfunction

  // Streams NF frames back to back; leaves in_valid low afterwards, sampled #1 past the last accept edge.
  task automatic load_query(input hv_t q);
    cur_q = q;
    for (int i = 0; i < NF; i++) begin
      int t;
      @(negedge clk);
      in_valid = 1'b1;
      in_frame = q[i];
      t = 0;
      while (!in_ready && t < 60) begin
        @(negedge clk);
        t++;
      end
      if (!in_ready) chk("load_timeout", 64'(in_ready), 64'd1);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
  endtask

  // Called #1 after the last accept edge; lat = edges until out_valid, fid_bad flags a wrong walk.
  task automatic wait_result(output int lat, output bit fid_bad);
    lat     = -1;
    fid_bad = 1'b0;
    for (int k = 0; k <= 40; k++) begin
      if (out_valid) begin
        lat = k;
        break;
      end
      if (frame_id !== 3'(k / NF) || frame_index !== 2'(k % NF)) fid_bad = 1'b1;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic accept_result();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  vec_t vt[6];

  initial begin
    hv_t q;
    int  lat;
    bit  fid_bad;
    bit  stable_bad;
    bit  rdy_bad;
    bit  ov_bad;
    logic [2:0] held_class;
    logic [7:0] held_dist;

    n_chk     = 0;
    n_err     = 0;
    mode      = 0;
    cur_q     = '0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_frame  = '0;
    out_ready = 1'b0;

    // Vector table.
    vt[0] = '{name: "class3_exact", mode: 0, q: class_hv(3), exp_class: 3'd3, exp_dist: 8'd0};
    q = class_hv(5);
    q[0][0]  = ~q[0][0];
    q[0][63] = ~q[0][63];
    q[1][10] = ~q[1][10];
    q[2][40] = ~q[2][40];
    vt[1] = '{name: "class5_flip4", mode: 0, q: q, exp_class: 3'd5, exp_dist: 8'd4};
    vt[2] = '{name: "all_ones_tie", mode: 1, q: '0, exp_class: 3'd0, exp_dist: 8'd192};
    q = {64'h0123456789ABCDEF, 64'hF0F0F0F00F0F0F0F, 64'hA5A5A5A55A5A5A5A};
    vt[3] = '{name: "cls2_6_tie", mode: 2, q: q, exp_class: 3'd2, exp_dist: 8'd0};
    vt[4] = '{name: "desc_dist", mode: 3, q: q, exp_class: 3'd7, exp_dist: 8'd1};
    q = class_hv(7);
    q[2][7:0] = ~q[2][7:0];
    vt[5] = '{name: "class7_flip8", mode: 0, q: q, exp_class: 3'd7, exp_dist: 8'd8};

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_class", 64'(out_class), 64'd0);
    chk("rst_out_dist", 64'(out_dist), 64'd0);
    chk("rst_frame_id", 64'(frame_id), 64'd0);
    chk("rst_frame_index", 64'(frame_index), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table-driven searches.
    for (int i = 0; i < 6; i++) begin
      mode = vt[i].mode;
      load_query(vt[i].q);
      wait_result(lat, fid_bad);
      chk({vt[i].name, "_latency"}, 64'(lat), 64'd24);
      chk({vt[i].name, "_walk"}, 64'(fid_bad), 64'd0);
      chk({vt[i].name, "_class"}, 64'(out_class), 64'(vt[i].exp_class));
      chk({vt[i].name, "_dist"}, 64'(out_dist), 64'(vt[i].exp_dist));
      accept_result();
      chk({vt[i].name, "_ov_drop"}, 64'(out_valid), 64'd0);
    end

    // Backpressure: result held 10 cycles with in_valid high, then a second query.
    mode = 0;
    load_query(class_hv(4));
    wait_result(lat, fid_bad);
    chk("bp_latency", 64'(lat), 64'd24);
    held_class = out_class;
    held_dist  = out_dist;
    chk("bp_class", 64'(held_class), 64'd4);
    chk("bp_dist", 64'(held_dist), 64'd0);
    in_valid   = 1'b1;
    in_frame   = 64'hDEADBEEFDEADBEEF;
    stable_bad = 1'b0;
    rdy_bad    = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1;
      if (!out_valid || out_class !== held_class || out_dist !== held_dist) stable_bad = 1'b1;
      if (in_ready !== 1'b0) rdy_bad = 1'b1;
    end
    chk("bp_outputs_stable", 64'(stable_bad), 64'd0);
    chk("bp_in_ready_low", 64'(rdy_bad), 64'd0);
    accept_result();
    chk("bp_in_ready_back", 64'(in_ready), 64'd1);
    load_query(class_hv(1));
    wait_result(lat, fid_bad);
    chk("bp2_latency", 64'(lat), 64'd24);
    chk("bp2_class", 64'(out_class), 64'd1);
    chk("bp2_dist", 64'(out_dist), 64'd0);
    accept_result();

    // Reset at the 10th search cycle.
    load_query(class_hv(2));
    repeat (9) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_frame_id", 64'(frame_id), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n  = 1'b1;
    ov_bad = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      if (out_valid !== 1'b0) ov_bad = 1'b1;
    end
    chk("midrst_no_result", 64'(ov_bad), 64'd0);
    chk("midrst_idle_ready", 64'(in_ready), 64'd1);
    load_query(class_hv(6));
    wait_result(lat, fid_bad);
    chk("postrst_latency", 64'(lat), 64'd24);
    chk("postrst_class", 64'(out_class), 64'd6);
    chk("postrst_dist", 64'(out_dist), 64'd0);
    accept_result();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
